// File: rtl/demux_1to2_tdm.sv
// Splits an A/B time-multiplexed sample stream into registered channel pairs (optional DEMUX_ERRCNT_EN adds err_cnt_out).
// Latency: one cycle from the B-slot edge to a_out/b_out/pair_valid_out; err_out is also registered one cycle after its cause.
// Backpressure: none; every valid sample is consumed on arrival, and framing faults are reported on err_out.
module demux_1to2_tdm #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  input  logic             sof_in,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             pair_valid_out,
  output logic             busy_out,
  output logic             err_out
`ifdef DEMUX_ERRCNT_EN
  ,
  output logic [7:0]       err_cnt_out
`endif
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {
    WAIT_A = 1'b0,
    WAIT_B = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_hold;
  logic [TW-1:0]    tmo_cnt;

  assign busy_out = (state == WAIT_B);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= WAIT_A;
      a_hold         <= '0;
      a_out          <= '0;
      b_out          <= '0;
      tmo_cnt        <= '0;
      pair_valid_out <= 1'b0;
      err_out        <= 1'b0;
    end else begin
      pair_valid_out <= 1'b0;
      err_out        <= 1'b0;
      case (state)
        WAIT_A: begin
          if (valid_in) begin
            if (sof_in) begin
              a_hold  <= data_in;
              tmo_cnt <= '0;
              state   <= WAIT_B;
            end else begin
              err_out <= 1'b1;
            end
          end
        end
        WAIT_B: begin
          if (valid_in) begin
            if (sof_in) begin
              // A slot arrived where B was expected: restart the frame on the new A.
              err_out <= 1'b1;
              a_hold  <= data_in;
              tmo_cnt <= '0;
            end else begin
              a_out          <= a_hold;
              b_out          <= data_in;
              pair_valid_out <= 1'b1;
              state          <= WAIT_A;
            end
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            err_out <= 1'b1;
            a_hold  <= '0;
            tmo_cnt <= '0;
            state   <= WAIT_A;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: state <= WAIT_A;
      endcase
    end
  end

`ifdef DEMUX_ERRCNT_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      err_cnt_out <= 8'd0;
    end else if (err_out && (err_cnt_out != 8'hFF)) begin
      err_cnt_out <= err_cnt_out + 8'd1;
    end
  end
`endif

endmodule
